// File: rtl/rdma_rx_filter.sv
// rdma_rx_filter: screens MAC RX frames by their 64-byte header beat and forwards only
// well-formed RDMA packets through a registered output stage with a one-entry skid buffer.
module rdma_rx_filter #(
    parameter int          DATA_WBITS = 512,
    parameter int          DATA_WBYTS = DATA_WBITS / 8,
    parameter logic [15:0] RDMA_MAGIC = 16'h0122,
    parameter int          MAX_DBYTES = 16384
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WBITS-1:0] S_AXIS_TDATA,
    input  logic [DATA_WBYTS-1:0] S_AXIS_TKEEP,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_WBITS-1:0] M_AXIS_TDATA,
    output logic [DATA_WBYTS-1:0] M_AXIS_TKEEP,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic [63:0]           packets_passed,
    output logic [63:0]           packets_dropped,
    output logic [3:0]            drop_reason
);

    typedef enum logic [1:0] {HDR, PASS, DROP} state_e;

    localparam logic [15:0] MaxDBytes = 16'(MAX_DBYTES);
    localparam int          BeatW     = DATA_WBITS + DATA_WBYTS + 1;

    state_e           state_q, state_d;
    logic [15:0]      ethType, udpLength, magicField, dBytes;
    logic [7:0]       ipProto;
    logic             lengthOk;
    logic [3:0]       hdrReason;
    logic             hdrOk, accept, push, hdrPass, hdrDrop, pop;
    logic [BeatW-1:0] inBeat, main_q, skid_q;
    logic             mainValid_q, skidValid_q;
    logic [63:0]      passed_q, dropped_q;
    logic [3:0]       reason_q;

    // Wire byte n sits in TDATA[8n+7:8n]; multi-byte fields are big-endian on the wire.
    assign ethType    = {S_AXIS_TDATA[12*8 +: 8], S_AXIS_TDATA[13*8 +: 8]};
    assign ipProto    = S_AXIS_TDATA[23*8 +: 8];
    assign udpLength  = {S_AXIS_TDATA[38*8 +: 8], S_AXIS_TDATA[39*8 +: 8]};
    assign magicField = {S_AXIS_TDATA[42*8 +: 8], S_AXIS_TDATA[43*8 +: 8]};
    assign dBytes     = udpLength - 16'd30;
    assign lengthOk   = (udpLength >= 16'd31) && (dBytes <= MaxDBytes);

    always_comb begin
        hdrReason[0] = (ethType != 16'h0800);
        hdrReason[1] = (ipProto != 8'h11);
        hdrReason[2] = (magicField != RDMA_MAGIC);
        hdrReason[3] = !lengthOk || (S_AXIS_TKEEP != '1) || S_AXIS_TLAST || !enable;
    end

    assign hdrOk = (hdrReason == 4'd0);

    // Ready depends only on registered state, so downstream backpressure never reaches S_AXIS combinationally.
    assign S_AXIS_TREADY = (state_q == DROP) || !skidValid_q;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (accept) begin
                    if (hdrOk) begin
                        state_d = PASS;
                    end else if (!S_AXIS_TLAST) begin
                        state_d = DROP;
                    end
                end
            end
            PASS, DROP: begin
                if (accept && S_AXIS_TLAST) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        push    = 1'b0;
        hdrPass = 1'b0;
        hdrDrop = 1'b0;
        case (state_q)
            HDR: begin
                hdrPass = accept && hdrOk;
                hdrDrop = accept && !hdrOk;
                push    = accept && hdrOk;
            end
            PASS:    push = accept;
            default: push = 1'b0;
        endcase
    end

    assign inBeat = {S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST};
    assign pop    = mainValid_q && M_AXIS_TREADY;

    // A push only happens with the skid empty, so it lands in main unless main is held by a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
        end else if (push) begin
            if (!mainValid_q || pop) begin
                mainValid_q <= 1'b1;
                main_q      <= inBeat;
            end else begin
                skidValid_q <= 1'b1;
                skid_q      <= inBeat;
            end
        end else if (pop) begin
            if (skidValid_q) begin
                main_q      <= skid_q;
                skidValid_q <= 1'b0;
            end else begin
                mainValid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            passed_q  <= 64'd0;
            dropped_q <= 64'd0;
            reason_q  <= 4'd0;
        end else begin
            if (hdrPass) begin
                passed_q <= passed_q + 64'd1;
            end
            if (hdrDrop) begin
                dropped_q <= dropped_q + 64'd1;
                reason_q  <= hdrReason;
            end
        end
    end

    assign {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} = main_q;
    assign M_AXIS_TVALID   = mainValid_q;
    assign packets_passed  = passed_q;
    assign packets_dropped = dropped_q;
    assign drop_reason     = reason_q;

endmodule
